// File: rtl/stream_packer.sv
// stream_packer
//   Output-side packing stage. Pairs consecutive 32-bit accumulator results
//   into 64-bit beats (later result in the high word), buffers the beats in a
//   DEPTH-entry fall-through FIFO and presents them on an AXI Stream master
//   port with TLAST on the beat that carries the job's final result. An odd
//   final result is padded with a zero high word.
//
//   Optional feature macro: STREAM_PACKER_OVF_EN
//     defined   -> overflow is a sticky flag set when a beat is dropped
//     undefined -> overflow is tied low (beats are still dropped when full)
//
// Parameters
//   DEPTH      FIFO depth in 64-bit beats (power of two, >= 2)
// Ports
//   clk        single clock
//   rst        synchronous active-high reset (priority over everything)
//   run        job enable; low clears all state like rst
//   res_v      result valid (one cycle per result, no back-pressure)
//   res_d      32-bit result data
//   res_last   marks the final result of the job
//   dst_ready  M_AXIS_TREADY
//   dst_valid  M_AXIS_TVALID
//   dst_data   M_AXIS_TDATA
//   dst_last   M_AXIS_TLAST
//   full       FIFO holds DEPTH beats (registered)
//   overflow   sticky beat-dropped flag

module stream_packer #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        res_v,
  input  logic [31:0] res_d,
  input  logic        res_last,
  input  logic        dst_ready,
  output logic        dst_valid,
  output logic [63:0] dst_data,
  output logic        dst_last,
  output logic        full,
  output logic        overflow
);

  localparam int              AW        = $clog2(DEPTH);
  localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
  localparam logic [AW:0]     CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]     DEPTH_CNT = (AW+1)'(DEPTH);

  // Pairing register
  logic [31:0]   lo_q, lo_d;
  logic          half_q, half_d;

  // FIFO storage: bit 64 is the last flag, bits 63:0 the beat data
  logic [64:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q;

  logic          clear;
  logic          push;
  logic          pop;
  logic          do_write;
  logic [64:0]   push_beat;

  // run low behaves exactly like rst
  assign clear = rst | ~run;

  // Pairing and FIFO control. A beat is produced either when a second result
  // completes the pair or when a lone final result must be padded. A push into
  // a full FIFO only succeeds if a pop frees the slot on the same edge.
  always_comb begin
    lo_d      = lo_q;
    half_d    = half_q;
    push      = res_v & (half_q | res_last);
    push_beat = half_q ? {res_last, res_d, lo_q} : {1'b1, 32'h0, res_d};
    pop       = (count_q != '0) & dst_ready;
    do_write  = push & ((count_q != DEPTH_CNT) | pop);

    if (res_v) begin
      if (half_q) begin
        half_d = 1'b0;
      end else if (!res_last) begin
        lo_d   = res_d;
        half_d = 1'b1;
      end
    end

    wr_ptr_d = do_write ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop      ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    case ({do_write, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control state register; full is registered from the next count so it
  // tracks the occupancy visible in the following cycle.
  always_ff @(posedge clk) begin
    if (clear) begin
      lo_q     <= '0;
      half_q   <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      lo_q     <= lo_d;
      half_q   <= half_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_CNT);
    end
  end

  // Storage array has no reset; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (!clear && do_write) begin
      mem_q[wr_ptr_q] <= push_beat;
    end
  end

`ifdef STREAM_PACKER_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky: set on the edge where a completed beat finds no room.
  always_comb begin
    ovf_d = ovf_q | (push & ~do_write);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  // Fall-through read port
  assign dst_valid = (count_q != '0);
  assign dst_data  = mem_q[rd_ptr_q][63:0];
  assign dst_last  = (count_q != '0) & mem_q[rd_ptr_q][64];
  assign full      = full_q;

endmodule

// File: tb/tb_stream_packer.sv
// tb_stream_packer
//   Randomised and directed bench for stream_packer (DEPTH = 16). A driver
//   issues results and derives the expected beats from a queue of pending
//   results; completed beats enter a scoreboard queue on the edge the DUT
//   writes them. A separate monitor compares the DUT's output port with the
//   scoreboard every cycle and retires beats on handshakes.

module tb_stream_packer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        res_v;
  logic [31:0] res_d;
  logic        res_last;
  logic        dst_ready;
  logic        dst_valid;
  logic [63:0] dst_data;
  logic        dst_last;
  logic        full;
  logic        overflow;

  stream_packer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .res_v     (res_v),
    .res_d     (res_d),
    .res_last  (res_last),
    .dst_ready (dst_ready),
    .dst_valid (dst_valid),
    .dst_data  (dst_data),
    .dst_last  (dst_last),
    .full      (full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Scoreboard: bit 64 = expected last flag
  logic [64:0] expQ[$];
  logic [31:0] held[$];
  logic [64:0] pendBeat;
  bit          pendValid;
  bit          pendDrop;
  bit          expOvf;
  bit          monOn;
  int          nChecks;
  int          nFails;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit expOverflow();
`ifdef STREAM_PACKER_OVF_EN
    return expOvf;
`else
    return 1'b0;
`endif
  endfunction

  // Commit whatever the DUT did on the edge just passed
  task automatic commitEdge();
    if (pendValid) expQ.push_back(pendBeat);
    if (pendDrop)  expOvf = 1'b1;
    pendValid = 1'b0;
    pendDrop  = 1'b0;
  endtask

  // One cycle of stimulus; the reference model decides what the next edge
  // produces from the pending results and the current scoreboard occupancy.
  task automatic applyStimulus(input bit v, input logic [31:0] d, input bit l, input bit rdy);
    logic [64:0] beat;
    @(posedge clk);
    commitEdge();
    #1;
    res_v     = v;
    res_d     = d;
    res_last  = l;
    dst_ready = rdy;
    if (v) begin
      held.push_back(d);
      if (held.size() == 2 || l) begin
        if (held.size() == 2) beat = {l, held[1], held[0]};
        else                  beat = {1'b1, 32'h0, held[0]};
        held.delete();
        if (expQ.size() == DEPTH && !rdy) pendDrop = 1'b1;
        else begin
          pendBeat  = beat;
          pendValid = 1'b1;
        end
      end
    end
  endtask

  // One cycle of run=0 (or rst=1), then the model is emptied
  task automatic clearCycle(input bit useRst);
    @(posedge clk);
    commitEdge();
    #1;
    res_v = 1'b0;
    res_last = 1'b0;
    if (useRst) rst = 1'b1;
    else        run = 1'b0;
    @(posedge clk);
    expQ.delete();
    held.delete();
    expOvf = 1'b0;
    #1;
    rst = 1'b0;
    run = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (expQ.size() == 0 && !pendValid) break;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    end
    checkOutput("drain_empty", 64'(expQ.size()), 64'd0);
  endtask

  // Monitor: compares outputs each cycle; handshake seen here takes effect
  // on the coming rising edge.
  always @(negedge clk) begin
    if (monOn && !rst && run) begin
      checkOutput("valid", 64'(dst_valid), 64'(expQ.size() != 0));
      checkOutput("full", 64'(full), 64'(expQ.size() == DEPTH));
      checkOutput("overflow", 64'(overflow), 64'(expOverflow()));
      if (dst_valid && expQ.size() != 0) begin
        checkOutput("data", dst_data, expQ[0][63:0]);
        checkOutput("last", 64'(dst_last), 64'(expQ[0][64]));
        if (dst_ready) void'(expQ.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    nChecks = 0;
    nFails = 0;
    monOn = 1'b0;
    pendValid = 1'b0;
    pendDrop = 1'b0;
    expOvf = 1'b0;
    rst = 1'b1;
    run = 1'b1;
    res_v = 1'b0;
    res_d = '0;
    res_last = 1'b0;
    dst_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", 64'(dst_valid), 64'd0);
    checkOutput("rst_last", 64'(dst_last), 64'd0);
    checkOutput("rst_full", 64'(full), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    monOn = 1'b1;

    // Basic pair
    applyStimulus(1'b1, 32'd1, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'd2, 1'b1, 1'b1);
    drain();

    // Odd pad
    applyStimulus(1'b1, 32'd5, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'd6, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'd7, 1'b1, 1'b1);
    drain();

    // Backpressure: exactly fills the FIFO
    for (int i = 0; i < 32; i++)
      applyStimulus(1'b1, 32'h100 + 32'(i), (i == 31), 1'b0);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    drain();

    // Overflow: the 17th beat is dropped
    for (int i = 0; i < 34; i++)
      applyStimulus(1'b1, 32'h200 + 32'(i), (i == 33), 1'b0);
    repeat (2) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    drain();
    clearCycle(1'b0);

    // Full push+pop on the same edge
    for (int i = 0; i < 32; i++)
      applyStimulus(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hAAAA_0002, 1'b1, 1'b1);
    drain();

    // Mid-job clear with buffered beats and a held low word
    for (int i = 0; i < 7; i++)
      applyStimulus(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0);
    clearCycle(1'b0);
    @(negedge clk);
    checkOutput("clear_valid", 64'(dst_valid), 64'd0);
    applyStimulus(1'b1, 32'd8, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'd9, 1'b1, 1'b1);
    drain();

    // Randomised traffic
    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom_range(0, 3) != 0), $urandom(),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
    drain();
    clearCycle(1'b0);

    // Reset while beats are buffered
    for (int i = 0; i < 9; i++)
      applyStimulus(1'b1, $urandom(), 1'b0, 1'b0);
    clearCycle(1'b1);
    @(negedge clk);
    checkOutput("rst2_valid", 64'(dst_valid), 64'd0);
    checkOutput("rst2_full", 64'(full), 64'd0);
    applyStimulus(1'b1, 32'hCAFE_0000, 1'b1, 1'b1);
    drain();

    monOn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
